// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer.
// ALU control codes, 1-bit slice op codes and FSM states.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic sub_cin(input logic [3:0] c);
    return (c == CTRL_SUB) || (c == CTRL_SLT);
  endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer feeding an external 1-bit ALU slice LSB-first
// and assembling the WIDTH-bit result and flags.
module bit_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             slice_src1_o,
  output logic             slice_src2_o,
  output logic             slice_less_o,
  output logic             slice_a_inv_o,
  output logic             slice_b_inv_o,
  output logic             slice_cin_o,
  output logic [1:0]       slice_op_o,
  input  logic             slice_result_i,
  input  logic             slice_cout_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             done_o
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-2:0] acc_q;
  logic [WIDTH-2:0] acc_nxt;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;

  logic [1:0]       op_d;
  logic             a_inv_d;
  logic             b_inv_d;
  logic             arith_d;
  logic             slt_d;
  logic             valid_d;
  logic             run;
  logic             ovf;
  logic [WIDTH-1:0] res_d;
  logic             cout_d;
  logic             ovf_d;

  always_comb begin
    op_d    = OP_AND;
    a_inv_d = 1'b0;
    b_inv_d = 1'b0;
    arith_d = 1'b0;
    slt_d   = 1'b0;
    valid_d = 1'b1;
    unique case (1'b1)
      (ctrl_q == CTRL_AND): op_d = OP_AND;
      (ctrl_q == CTRL_OR):  op_d = OP_OR;
      (ctrl_q == CTRL_NOR): begin
        a_inv_d = 1'b1;
        b_inv_d = 1'b1;
      end
      (ctrl_q == CTRL_ADD): begin
        op_d    = OP_ADD;
        arith_d = 1'b1;
      end
      (ctrl_q == CTRL_SUB): begin
        op_d    = OP_ADD;
        b_inv_d = 1'b1;
        arith_d = 1'b1;
      end
      (ctrl_q == CTRL_SLT): begin
        op_d    = OP_ADD;
        b_inv_d = 1'b1;
        slt_d   = 1'b1;
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Slice is only driven while running so idle/reset shows all zeros.
  assign run           = (state_q == ST_RUN);
  assign slice_src1_o  = run & a_q[idx_q];
  assign slice_src2_o  = run & b_q[idx_q];
  assign slice_less_o  = 1'b0;
  assign slice_a_inv_o = run & a_inv_d;
  assign slice_b_inv_o = run & b_inv_d;
  assign slice_cin_o   = run & carry_q;
  assign slice_op_o    = run ? op_d : OP_AND;

  always_comb begin
    acc_nxt            = acc_q >> 1;
    acc_nxt[WIDTH-2]   = slice_result_i;
  end

  // carry_q holds the carry into the MSB on the last RUN cycle.
  assign ovf = carry_q ^ slice_cout_i;

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    if (slt_d) begin
      res_d[0] = slice_result_i ^ ovf;
    end else if (valid_d) begin
      res_d = {slice_result_i, acc_q};
      if (arith_d) begin
        cout_d = slice_cout_i;
        ovf_d  = ovf;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && ready_q) begin
            a_q     <= src1_i;
            b_q     <= src2_i;
            ctrl_q  <= ctrl_i;
            idx_q   <= '0;
            carry_q <= sub_cin(ctrl_i);
            acc_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= slice_cout_i;
          if (idx_q == IDX_LAST) begin
            result_q <= res_d;
            zero_q   <= (res_d == '0);
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule
